// File: rtl/alu_register_bank_pkg.sv
// alu_register_bank_pkg: shared widths, LOAD bit positions and reset value for the TD4 execute stage
package alu_register_bank_pkg;
    localparam int DATA_W  = 4;
    localparam int LD_A    = 0;
    localparam int LD_B    = 1;
    localparam int LD_OUT  = 2;
    localparam int LD_PC   = 3;
    localparam int RST_VAL = 0;
endpackage

// File: rtl/alu_register_bank_load_register.sv
// load_register: parallel-load register with async active-high reset and step enable
module load_register
    import alu_register_bank_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            q <= W'(RST_VAL);
        else if (en && ld)
            q <= d;
endmodule

// File: rtl/alu_register_bank.sv
// alu_register_bank: TD4 execute/write-back stage, adds Y+IM and writes it to A, B, OUT or PC
module alu_register_bank
    import alu_register_bank_pkg::*;
#(
    parameter int bitWidth = DATA_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [bitWidth-1:0] Y,
    input  logic [bitWidth-1:0] IM,
    input  logic [3:0]          LOAD,
    output logic [bitWidth-1:0] SUM,
    output logic                CO,
    output logic [bitWidth-1:0] A,
    output logic [bitWidth-1:0] B,
    output logic [bitWidth-1:0] OUT,
    output logic [bitWidth-1:0] PC,
    output logic                C
);
    assign {CO, SUM} = {1'b0, Y} + {1'b0, IM};
    load_register #(.W(bitWidth)) u_a (
        .clk(CLK), .rst(RST), .en(EN), .ld(LOAD[LD_A]), .d(SUM), .q(A)
    );
    load_register #(.W(bitWidth)) u_b (
        .clk(CLK), .rst(RST), .en(EN), .ld(LOAD[LD_B]), .d(SUM), .q(B)
    );
    load_register #(.W(bitWidth)) u_out (
        .clk(CLK), .rst(RST), .en(EN), .ld(LOAD[LD_OUT]), .d(SUM), .q(OUT)
    );
    // carry flag tracks every enabled step, even when nothing is loaded
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            PC <= bitWidth'(RST_VAL);
            C  <= 1'b0;
        end else if (EN) begin
            PC <= LOAD[LD_PC] ? SUM : PC + 1'b1;
            C  <= CO;
        end
endmodule

// File: tb/tb_alu_register_bank.sv
// tb_alu_register_bank: table-driven scoreboard bench for alu_register_bank
module tb_alu_register_bank;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b1;
    logic [3:0]  Y = 4'h9;
    logic [3:0]  IM = 4'h3;
    logic [3:0]  LOAD = 4'hF;
    logic [3:0]  SUM, A, B, OUT, PC;
    logic        CO, C;
    int          passed = 0;
    int          total = 0;
    logic [16:0] sb_q[$];
    logic [16:0] exp_st;

    typedef struct {
        logic        en;
        logic [3:0]  y;
        logic [3:0]  im;
        logic [3:0]  load;
        logic [4:0]  sumco;
        logic [16:0] st;
    } vec_t;
    vec_t vecs[13];

    alu_register_bank #(.bitWidth(4)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .Y(Y), .IM(IM), .LOAD(LOAD),
        .SUM(SUM), .CO(CO), .A(A), .B(B), .OUT(OUT), .PC(PC), .C(C)
    );

    always #5 CLK = ~CLK;

    function automatic logic [16:0] st_now();
        return {A, B, OUT, PC, C};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic step_check(input string name);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty, got %h expected entry", name, st_now());
        end else begin
            exp_st = sb_q.pop_front();
            check(name, st_now(), exp_st);
        end
    endtask

    initial begin
        // {en, y, im, load, {CO,SUM}, {A,B,OUT,PC,C}}
        vecs[0]  = '{1'b1, 4'h3, 4'h5, 4'b0001, 5'h08, {4'h8, 4'h0, 4'h0, 4'h1, 1'b0}};
        vecs[1]  = '{1'b1, 4'h3, 4'h5, 4'b0010, 5'h08, {4'h8, 4'h8, 4'h0, 4'h2, 1'b0}};
        vecs[2]  = '{1'b1, 4'h9, 4'h9, 4'b0100, 5'h12, {4'h8, 4'h8, 4'h2, 4'h3, 1'b1}};
        vecs[3]  = '{1'b1, 4'h0, 4'h0, 4'b0000, 5'h00, {4'h8, 4'h8, 4'h2, 4'h4, 1'b0}};
        vecs[4]  = '{1'b1, 4'h0, 4'hE, 4'b1000, 5'h0E, {4'h8, 4'h8, 4'h2, 4'hE, 1'b0}};
        vecs[5]  = '{1'b1, 4'h0, 4'h0, 4'b0000, 5'h00, {4'h8, 4'h8, 4'h2, 4'hF, 1'b0}};
        vecs[6]  = '{1'b1, 4'h0, 4'h0, 4'b0000, 5'h00, {4'h8, 4'h8, 4'h2, 4'h0, 1'b0}};
        vecs[7]  = '{1'b1, 4'h7, 4'h1, 4'b1111, 5'h08, {4'h8, 4'h8, 4'h8, 4'h8, 1'b0}};
        vecs[8]  = '{1'b0, 4'hF, 4'hF, 4'b1111, 5'h1E, {4'h8, 4'h8, 4'h8, 4'h8, 1'b0}};
        vecs[9]  = '{1'b0, 4'hF, 4'hF, 4'b1111, 5'h1E, {4'h8, 4'h8, 4'h8, 4'h8, 1'b0}};
        vecs[10] = '{1'b0, 4'hF, 4'hF, 4'b1111, 5'h1E, {4'h8, 4'h8, 4'h8, 4'h8, 1'b0}};
        vecs[11] = '{1'b1, 4'hF, 4'hF, 4'b0001, 5'h1E, {4'hE, 4'h8, 4'h8, 4'h9, 1'b1}};
        vecs[12] = '{1'b0, 4'h1, 4'h2, 4'b0000, 5'h03, {4'hE, 4'h8, 4'h8, 4'h9, 1'b1}};

        #1;
        check("reset_async_initial", st_now(), 17'h0);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(17'h0);
            step_check($sformatf("reset_hold_%0d", i));
        end
        check("reset_comb_sum", {12'h0, CO, SUM}, 17'h0C);

        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge CLK);
            EN = vecs[i].en;
            Y = vecs[i].y;
            IM = vecs[i].im;
            LOAD = vecs[i].load;
            sb_q.push_back(vecs[i].st);
            #1;
            check($sformatf("vec%0d_sumco", i), {12'h0, CO, SUM}, {12'h0, vecs[i].sumco});
            step_check($sformatf("vec%0d_state", i));
        end

        // async reset between edges clears nonzero state before the next edge
        @(negedge CLK);
        EN = 1'b1;
        Y = 4'h9;
        IM = 4'h3;
        LOAD = 4'hF;
        #1;
        RST = 1'b1;
        #1;
        check("midop_async_reset", st_now(), 17'h0);
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(17'h0);
            step_check($sformatf("midop_reset_hold_%0d", i));
        end

        // first edge after release behaves normally
        @(negedge CLK);
        RST = 1'b0;
        LOAD = 4'b0001;
        sb_q.push_back({4'hC, 4'h0, 4'h0, 4'h1, 1'b0});
        step_check("post_reset_first_edge");

        @(negedge CLK);
        LOAD = 4'b0000;
        Y = 4'hF;
        IM = 4'h1;
        sb_q.push_back({4'hC, 4'h0, 4'h0, 4'h2, 1'b1});
        step_check("load0_carry_only");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout, got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_register_bank.md
Name: alu_register_bank

Overview:
- Execute/write-back stage of the TD4 datapath. It sits directly downstream of DataSelector.
- Adds the selector output Y to the instruction immediate IM, and writes the sum into any of registers A, B, OUT or PC. It also captures the carry flag.
- PC auto-increments on every enabled cycle that does not load it.
- Registered A and B feed back into the selector's A/B inputs; C feeds the instruction decoder for JNC.

Parameters:
- bitWidth, 4, width of data path, immediate, registers and PC.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset; asynchronous, active-high.
- EN  input  1  instruction-step enable; when low, all state holds.
- Y  input  bitWidth  operand from DataSelector output.
- IM  input  bitWidth  immediate field of current instruction.
- LOAD  input  4  write enables, active-high: bit0=A, bit1=B, bit2=OUT, bit3=PC.
- SUM  output  bitWidth  combinational Y+IM, low bitWidth bits.
- CO  output  1  combinational carry out of Y+IM.
- A  output  bitWidth  register A.
- B  output  bitWidth  register B.
- OUT  output  bitWidth  output-port register.
- PC  output  bitWidth  program counter.
- C  output  1  registered carry flag.

Behaviour:
- Reset:
  - RST high forces A, B, OUT, PC to 0 and C to 0 immediately, independent of CLK.
  - RST high overrides EN and LOAD. State stays at 0 while RST is high.
  - The first rising edge after RST falls behaves as a normal edge.
  - Reset asserted mid-operation discards any pending load; nothing is buffered.
- Adder:
  - {CO,SUM} = Y + IM, computed at bitWidth+1 bits, unsigned. No signed handling.
  - Purely combinational, same-cycle. Valid whatever EN/LOAD are.
- Rising CLK edge with EN=1:
  - Each register whose LOAD bit is set takes SUM. Registers with the bit clear hold.
  - Several LOAD bits set at once: every selected register loads the same SUM in the same edge. This is legal, not an error.
  - PC: if LOAD[3]=1, PC <= SUM (jump). Otherwise PC <= PC+1, modulo 2^bitWidth; 4'hF wraps to 4'h0.
  - C <= CO on every enabled edge, regardless of LOAD, including LOAD=0 (TD4 flag semantics).
- Rising CLK edge with EN=0: A, B, OUT, PC and C all hold. PC does not increment.
- Latency:
  - Registered outputs change exactly one edge after inputs are sampled.
  - Register feedback through the selector is therefore stable for the next instruction.
  - SUM/CO have zero latency.
- Adder overflow: SUM wraps, CO=1. The register still loads the wrapped SUM.
- No X propagation: every register has a defined reset value; no latches.

Decomposition:
- Shared package holds:
  - default data width constant (4);
  - LOAD bit index constants LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3;
  - reset value constant (0).
- Sub-module load_register:
  - bitWidth-wide register with async active-high reset, enable and parallel load.
  - Instantiated for A, B and OUT.
  - PC and C are coded in the parent because of the increment and always-update rules.

Test Plan:
- Reset: drive RST=1 with LOAD=4'hF, Y=4'h9, IM=4'h3, EN=1 over several edges -> A=B=OUT=PC=0, C=0 throughout. Assert RST between edges and check outputs go 0 before the next edge.
- Load A/B, no carry: EN=1, Y=4'h3, IM=4'h5, LOAD=4'b0001 -> SUM=8, CO=0 combinationally; after edge A=8, B unchanged, PC=1, C=0. Repeat with LOAD=4'b0010 -> B=8, PC=2.
- Carry and wrap: Y=4'h9, IM=4'h9, LOAD=4'b0100 -> SUM=2, CO=1; after edge OUT=2, C=1. Next edge with Y=0, IM=0, LOAD=0 -> C=0, A/B/OUT hold, PC increments.
- Jump vs increment and wrap: LOAD=4'b1000, Y=0, IM=4'hE -> PC=E; next edge LOAD=0 -> PC=F; next -> PC=0.
- Simultaneous loads plus enable hold: LOAD=4'b1111, Y=4'h7, IM=4'h1 -> A=B=OUT=PC=8 after one edge. Then EN=0 with LOAD=4'b1111, Y=4'hF, IM=4'hF for 3 edges -> all registers stay 8, C unchanged, while SUM=E and CO=1 are visible combinationally.
